// File: rtl/shot_controller.sv
// Two-tank shot sequencer: fire-key edge detection, per-tank launch/flight/cooldown
// FSMs, bullet retirement, hit detection, scoring and round reset.
module shot_controller #(
    parameter logic [7:0]  FIRE_KEY0  = 8'h09,
    parameter logic [7:0]  FIRE_KEY1  = 8'h33,
    parameter int unsigned COOLDOWN   = 30,
    parameter int unsigned MAX_FLIGHT = 120,
    parameter int unsigned HIT_RADIUS = 8,
    parameter int unsigned X_MAX      = 639,
    parameter int unsigned Y_MAX      = 479
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] Tank0X,
    input  logic [9:0] Tank0Y,
    input  logic [9:0] Tank1X,
    input  logic [9:0] Tank1Y,
    input  logic       Tank0Moving,
    input  logic       Tank1Moving,
    input  logic [9:0] Bullet0X,
    input  logic [9:0] Bullet0Y,
    input  logic [9:0] Bullet1X,
    input  logic [9:0] Bullet1Y,
    output logic       Fire0,
    output logic       Fire1,
    output logic       Kill0,
    output logic       Kill1,
    output logic       Active0,
    output logic       Active1,
    output logic       Hit0,
    output logic       Hit1,
    output logic [3:0] Score0,
    output logic [3:0] Score1,
    output logic       RoundReset
);

    localparam int unsigned CNT_TOP = (MAX_FLIGHT > COOLDOWN) ? MAX_FLIGHT : COOLDOWN;
    localparam int unsigned CW      = $clog2(CNT_TOP + 1);

    localparam logic [CW-1:0] FLIGHT_LAST = CW'(MAX_FLIGHT - 1);
    localparam logic [CW-1:0] COOL_LOAD   = CW'(COOLDOWN - 1);
    localparam logic [9:0]    RADIUS      = 10'(HIT_RADIUS);
    localparam logic [9:0]    X_LIM       = 10'(X_MAX);
    localparam logic [9:0]    Y_LIM       = 10'(Y_MAX);

    typedef enum logic [1:0] {IDLE, LAUNCH, FLIGHT, COOL} shot_state_t;

    shot_state_t   state_q [2];
    shot_state_t   state_d [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_d   [2];
    logic [3:0]    score_q [2];
    logic [3:0]    score_d [2];

    logic [7:0] key_prev;
    logic [1:0] fire_q, fire_d, kill_q, kill_d, active_q, active_d, hit_q, hit_d;
    logic [1:0] req, oob, moving;
    logic       round_q, round_d;

    logic [1:0][9:0] bul_x, bul_y;
    logic [1:0][7:0] fire_key;

    assign fire_key = {FIRE_KEY1, FIRE_KEY0};
    assign bul_x    = {Bullet1X, Bullet0X};
    assign bul_y    = {Bullet1Y, Bullet0Y};
    assign moving   = {Tank1Moving, Tank0Moving};

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic in_box(input logic [9:0] bx, input logic [9:0] by,
                                    input logic [9:0] tx, input logic [9:0] ty);
        return (abs_diff(bx, tx) < RADIUS) && (abs_diff(by, ty) < RADIUS);
    endfunction

    always_comb begin
        req      = '0;
        oob      = '0;
        fire_d   = '0;
        kill_d   = '0;
        active_d = '0;
        // The flight counter is still 0 on the first flight frame, so it gates the hit test.
        hit_d[0] = (state_q[0] == FLIGHT) && (cnt_q[0] != '0) &&
                   in_box(Bullet0X, Bullet0Y, Tank1X, Tank1Y);
        hit_d[1] = (state_q[1] == FLIGHT) && (cnt_q[1] != '0) &&
                   in_box(Bullet1X, Bullet1Y, Tank0X, Tank0Y);
        round_d  = |hit_d;

        for (int unsigned i = 0; i < 2; i++) begin
            req[i]     = (keycode == fire_key[i]) && (key_prev != fire_key[i]);
            oob[i]     = (bul_x[i] > X_LIM) || (bul_y[i] > Y_LIM);
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            score_d[i] = score_q[i];

            case (state_q[i])
                IDLE: begin
                    if (req[i] && moving[i]) begin
                        state_d[i] = LAUNCH;
                        fire_d[i]  = 1'b1;
                    end
                end
                LAUNCH: begin
                    state_d[i] = FLIGHT;
                    cnt_d[i]   = '0;
                end
                FLIGHT: begin
                    if (hit_d[i] || oob[i] || (cnt_q[i] == FLIGHT_LAST)) begin
                        state_d[i] = COOL;
                        cnt_d[i]   = COOL_LOAD;
                        kill_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                COOL: begin
                    if (cnt_q[i] == '0) state_d[i] = IDLE;
                    else                cnt_d[i]   = cnt_q[i] - 1'b1;
                end
            endcase

            // A round reset overrides any retirement or launch decided above.
            if (round_d) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
                fire_d[i]  = 1'b0;
                kill_d[i]  = (state_q[i] == FLIGHT);
            end

            active_d[i] = (state_d[i] == FLIGHT);
        end

        if (hit_d == 2'b01 && score_q[0] != 4'hF) score_d[0] = score_q[0] + 4'd1;
        if (hit_d == 2'b10 && score_q[1] != 4'hF) score_d[1] = score_q[1] + 4'd1;
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            key_prev <= '0;
            state_q  <= '{IDLE, IDLE};
            cnt_q    <= '{default: '0};
            score_q  <= '{default: '0};
            fire_q   <= '0;
            kill_q   <= '0;
            active_q <= '0;
            hit_q    <= '0;
            round_q  <= 1'b0;
        end else begin
            key_prev <= keycode;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score_q  <= score_d;
            fire_q   <= fire_d;
            kill_q   <= kill_d;
            active_q <= active_d;
            hit_q    <= hit_d;
            round_q  <= round_d;
        end
    end

    assign Fire0      = fire_q[0];
    assign Fire1      = fire_q[1];
    assign Kill0      = kill_q[0];
    assign Kill1      = kill_q[1];
    assign Active0    = active_q[0];
    assign Active1    = active_q[1];
    assign Hit0       = hit_q[0];
    assign Hit1       = hit_q[1];
    assign Score0     = score_q[0];
    assign Score1     = score_q[1];
    assign RoundReset = round_q;

endmodule

// File: tb/tb_shot_controller.sv
// Directed-vector bench for shot_controller: table of single-frame vectors plus
// hand-written sequences for flight expiry, cooldown, reset and score saturation.
module tb_shot_controller;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] Tank0X, Tank0Y, Tank1X, Tank1Y;
    logic       Tank0Moving, Tank1Moving;
    logic [9:0] Bullet0X, Bullet0Y, Bullet1X, Bullet1Y;
    logic       Fire0, Fire1, Kill0, Kill1, Active0, Active1, Hit0, Hit1, RoundReset;
    logic [3:0] Score0, Score1;

    int unsigned errors = 0;
    int unsigned checks = 0;

    shot_controller #(
        .FIRE_KEY0(8'h09), .FIRE_KEY1(8'h33), .COOLDOWN(30), .MAX_FLIGHT(120),
        .HIT_RADIUS(8), .X_MAX(639), .Y_MAX(479)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .Tank0X(Tank0X), .Tank0Y(Tank0Y), .Tank1X(Tank1X), .Tank1Y(Tank1Y),
        .Tank0Moving(Tank0Moving), .Tank1Moving(Tank1Moving),
        .Bullet0X(Bullet0X), .Bullet0Y(Bullet0Y), .Bullet1X(Bullet1X), .Bullet1Y(Bullet1Y),
        .Fire0(Fire0), .Fire1(Fire1), .Kill0(Kill0), .Kill1(Kill1),
        .Active0(Active0), .Active1(Active1), .Hit0(Hit0), .Hit1(Hit1),
        .Score0(Score0), .Score1(Score1), .RoundReset(RoundReset)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Pulse field order: {Fire0,Fire1, Kill0,Kill1, Active0,Active1, Hit0,Hit1, RoundReset}
    typedef struct {
        string      name;
        logic [7:0] key;
        logic       m0, m1;
        logic [9:0] b0x, b0y, b1x, b1y;
        logic [8:0] pulses;
        logic [3:0] s0, s1;
    } vec_t;

    vec_t vecs[$];

    // Tank0 at (100,100), Tank1 at (500,300); parked bullet spots clear of both.
    localparam logic [9:0] S0X = 10'd300, S0Y = 10'd200, S1X = 10'd300, S1Y = 10'd250;

    task automatic add(input string n, input logic [7:0] k, input logic m0, input logic m1,
                       input logic [9:0] b0x, input logic [9:0] b0y,
                       input logic [9:0] b1x, input logic [9:0] b1y,
                       input logic [8:0] p, input logic [3:0] s0, input logic [3:0] s1);
        vec_t v;
        v.name = n; v.key = k; v.m0 = m0; v.m1 = m1;
        v.b0x = b0x; v.b0y = b0y; v.b1x = b1x; v.b1y = b1y;
        v.pulses = p; v.s0 = s0; v.s1 = s1;
        vecs.push_back(v);
    endtask

    function automatic logic [16:0] outs();
        return {Fire0, Fire1, Kill0, Kill1, Active0, Active1, Hit0, Hit1, RoundReset,
                Score0, Score1};
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic park();
        Bullet0X = S0X; Bullet0Y = S0Y; Bullet1X = S1X; Bullet1Y = S1Y;
    endtask

    // Fire tank 0 from IDLE and strike tank 1 on the second flight frame.
    task automatic hit0_round(input logic [3:0] es0, input logic [3:0] es1);
        keycode = 8'h09; step();
        keycode = 8'h00; step();
        step();
        Bullet0X = 10'd505; Bullet0Y = 10'd293; step();
        check("hit0_round", 32'(outs()), 32'({9'b00_10_00_10_1, es0, es1}));
        park();
    endtask

    initial begin
        int unsigned fires, act_frames, kill_at;
        logic        first_active;

        Reset = 1'b0; keycode = 8'h00;
        Tank0X = 10'd100; Tank0Y = 10'd100; Tank1X = 10'd500; Tank1Y = 10'd300;
        Tank0Moving = 1'b1; Tank1Moving = 1'b1;
        park();

        add("reset_idle",        8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_00_00_0, 0, 0);
        add("fire0_edge",        8'h09, 1, 1, S0X, S0Y, S1X, S1Y, 9'b10_00_00_00_0, 0, 0);
        add("fire0_held",        8'h09, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_10_00_0, 0, 0);
        add("flight0",           8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_10_00_0, 0, 0);
        add("fire1_edge",        8'h33, 1, 1, S0X, S0Y, S1X, S1Y, 9'b01_00_10_00_0, 0, 0);
        add("both_fly",          8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_11_00_0, 0, 0);
        add("oob0_x640",         8'h00, 1, 1, 640, S0Y, S1X, S1Y, 9'b00_10_01_00_0, 0, 0);
        add("cool0",             8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_01_00_0, 0, 0);
        add("cool0_drop",        8'h09, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_01_00_0, 0, 0);
        add("hit1",              8'h00, 1, 1, S0X, S0Y,  97, 107, 9'b00_01_00_01_1, 0, 1);
        add("refire_after_rr",   8'h09, 1, 1, S0X, S0Y, S1X, S1Y, 9'b10_00_00_00_0, 0, 1);
        add("flight0_b",         8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_10_00_0, 0, 1);
        add("no_hit_first_frame",8'h00, 1, 1, 500, 300, S1X, S1Y, 9'b00_00_10_00_0, 0, 1);
        add("edge_dx8",          8'h00, 1, 1, 508, 300, S1X, S1Y, 9'b00_00_10_00_0, 0, 1);
        add("hit0",              8'h00, 1, 1, 505, 293, S1X, S1Y, 9'b00_10_00_10_1, 1, 1);
        add("after_hit",         8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_00_00_0, 1, 1);
        add("fire1_stationary",  8'h33, 1, 0, S0X, S0Y, S1X, S1Y, 9'b00_00_00_00_0, 1, 1);
        add("release1",          8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_00_00_0, 1, 1);
        add("fire1_no_cool",     8'h33, 1, 1, S0X, S0Y, S1X, S1Y, 9'b01_00_00_00_0, 1, 1);
        add("flight1",           8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_01_00_0, 1, 1);
        add("fire0_again",       8'h09, 1, 1, S0X, S0Y, S1X, S1Y, 9'b10_00_01_00_0, 1, 1);
        add("both_fly_b",        8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_11_00_0, 1, 1);
        add("both_fly_c",        8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_11_00_0, 1, 1);
        add("draw",              8'h00, 1, 1, 505, 293,  97, 107, 9'b00_11_00_11_1, 1, 1);
        add("after_draw",        8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_00_00_0, 1, 1);
        add("fire0_y",           8'h09, 1, 1, S0X, S0Y, S1X, S1Y, 9'b10_00_00_00_0, 1, 1);
        add("flight0_y",         8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_10_00_0, 1, 1);
        add("y479_legal",        8'h00, 1, 1, S0X, 479, S1X, S1Y, 9'b00_00_10_00_0, 1, 1);
        add("oob0_y480",         8'h00, 1, 1, S0X, 480, S1X, S1Y, 9'b00_10_00_00_0, 1, 1);
        add("cool0_y",           8'h00, 1, 1, S0X, S0Y, S1X, S1Y, 9'b00_00_00_00_0, 1, 1);

        #12 Reset = 1'b1;

        foreach (vecs[i]) begin
            keycode = vecs[i].key; Tank0Moving = vecs[i].m0; Tank1Moving = vecs[i].m1;
            Bullet0X = vecs[i].b0x; Bullet0Y = vecs[i].b0y;
            Bullet1X = vecs[i].b1x; Bullet1Y = vecs[i].b1y;
            step();
            check(vecs[i].name, 32'(outs()), 32'({vecs[i].pulses, vecs[i].s0, vecs[i].s1}));
        end
        park(); keycode = 8'h00;
        for (int i = 0; i < 32; i++) step();

        // Held key, full-length flight, then cooldown boundary.
        keycode = 8'h09; step();
        check("held_fire_first", 32'(Fire0), 32'd1);
        fires = 1; act_frames = 0; kill_at = 0; first_active = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            keycode = (n <= 9) ? 8'h09 : 8'h00;
            step();
            if (n == 1) first_active = Active0;
            if (Fire0) fires++;
            if (Active0) act_frames++;
            if (Kill0) begin
                kill_at = n;
                break;
            end
        end
        check("held_active_next", 32'(first_active), 32'd1);
        check("held_fire_count", fires, 32'd1);
        check("flight_active_frames", act_frames, 32'd120);
        check("flight_kill_frame", kill_at, 32'd121);
        keycode = 8'h00;
        for (int m = 1; m <= 28; m++) step();
        keycode = 8'h09; step();
        check("cool_drop_29", 32'(Fire0), 32'd0);
        keycode = 8'h00; step();
        keycode = 8'h09; step();
        check("cool_accept_31", 32'(Fire0), 32'd1);
        keycode = 8'h00; step();
        step();
        Bullet0X = 10'd505; Bullet0Y = 10'd293; step();
        check("hit0_after_cool", 32'(outs()), 32'({9'b00_10_00_10_1, 4'd2, 4'd1}));
        park();

        hit0_round(4'd3, 4'd1);

        // Asynchronous reset in the middle of a flight.
        keycode = 8'h09; step();
        keycode = 8'h00; step();
        step();
        check("pre_reset_flight", 32'({Active0, Score0}), 32'({1'b1, 4'd3}));
        Reset = 1'b0;
        #2;
        check("reset_async", 32'(outs()), 32'd0);
        #2 Reset = 1'b1;
        step();
        check("post_reset_idle", 32'(outs()), 32'd0);

        for (int unsigned k = 1; k <= 16; k++)
            hit0_round((k > 15) ? 4'd15 : 4'(k), 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Per-round shot sequencer for the two-tank game; sits between the keyboard keycode and the two bullet instances.
- Turns fire keys into one-cycle launch commands, enforces one live bullet and a cooldown per tank, and retires bullets on range expiry or leaving the screen.
- Detects bullet-on-tank hits, keeps scores, and issues the one-cycle round reset that clears tanks and bullets.

Parameters:
- FIRE_KEY0, 8'h09, keycode that fires tank 0
- FIRE_KEY1, 8'h33, keycode that fires tank 1
- COOLDOWN, 30, frames after a bullet retires before that tank may fire again
- MAX_FLIGHT, 120, frames a bullet may fly before forced retirement
- HIT_RADIUS, 8, half-width of the hit box around a tank centre, in pixels
- X_MAX, 639, rightmost legal bullet X
- Y_MAX, 479, bottommost legal bullet Y

Ports:
- frame_clk  in  1  frame clock, the only clock
- Reset  in  1  asynchronous, active-low
- keycode  in  8  current key, 0 = none
- Tank0X, Tank0Y, Tank1X, Tank1Y  in  10 each  tank centres
- Tank0Moving, Tank1Moving  in  1 each  tank has nonzero motion
- Bullet0X, Bullet0Y, Bullet1X, Bullet1Y  in  10 each  bullet positions
- Fire0, Fire1  out  1 each  one-cycle launch command to a bullet
- Kill0, Kill1  out  1 each  one-cycle clear command to a bullet
- Active0, Active1  out  1 each  bullet is live
- Hit0, Hit1  out  1 each  one-cycle pulse: bullet N struck the other tank
- Score0, Score1  out  4 each  round wins
- RoundReset  out  1  one-cycle game reset (drives bullet/tank GReset)

Behaviour:
- Reset low: both FSMs go to IDLE; all counters, pulses, Active and Scores go to 0; key_prev goes to 0. Reset takes effect immediately, including mid-flight or mid-cooldown.
- All outputs are registered. Responses appear in the cycle after the sampling edge.
- Fire request N = (keycode == FIRE_KEYN) && (key_prev != FIRE_KEYN). key_prev is keycode registered each frame.
  - A held key fires once only.
  - Only one key can be valid per frame, so both tanks can never request in the same frame.
- Per-tank FSM, identical for N = 0 and 1 (other = 1-N):
  - IDLE: on request with TankNMoving = 1 -> LAUNCH. Request with TankNMoving = 0 is dropped and starts no cooldown.
  - LAUNCH: lasts 1 cycle with FireN = 1. Flight counter loads 0. Next state FLIGHT.
  - FLIGHT: ActiveN = 1, and the flight counter increments each frame.
    - Retire conditions, checked in priority order: hit, out-of-bounds, counter == MAX_FLIGHT-1.
    - Hit: |BulletNX - TankotherX| < HIT_RADIUS and |BulletNY - TankotherY| < HIT_RADIUS, unsigned difference via compare-and-subtract.
    - Out-of-bounds: BulletNX > X_MAX or BulletNY > Y_MAX (underflow wraps large and counts as out).
    - No hit check is made in the LAUNCH cycle or on the first FLIGHT frame.
    - On retire: KillN = 1 for 1 cycle, cooldown counter loads COOLDOWN-1, next state COOL.
  - COOL: counter decrements each frame; at 0 -> IDLE. Requests in COOL are dropped, not queued.
  - Requests in LAUNCH or FLIGHT are dropped.
- Hit handling:
  - Hit by N alone: HitN pulse, ScoreN increments (saturates at 15), and RoundReset pulses in the same cycle.
  - Both hits in the same frame: Hit0 and Hit1 both pulse, no score change, RoundReset pulses (draw).
  - RoundReset forces both FSMs to IDLE and clears cooldowns and flight counters. Scores are retained. Kill pulses for any live bullet.
- Active is 0 in IDLE and COOL and in the LAUNCH cycle, and 1 throughout FLIGHT.
- The two FSMs are independent apart from hit/RoundReset. Both may fly at once.

Test Plan:
- Reset low mid-FLIGHT with Score0 = 3 -> next observation: all outputs 0, Score0 = 0, both FSMs IDLE.
- keycode 8'h09 held 10 frames, Tank0Moving = 1 -> exactly one Fire0 pulse, one frame after the first frame; Active0 = 1 from the following frame.
- Fire0 with bullet flying clear of all edges -> Kill0 on frame 120 of flight. A new 8'h09 edge is ignored for 30 frames, then accepted.
- Bullet0X steps past 639 (to 640) -> Kill0 next cycle, no Hit0, Score0 unchanged.
- Bullet0 at (Tank1X+5, Tank1Y-7) in FLIGHT -> Hit0, Kill0 and RoundReset pulse once; Score0 +1. With Score0 = 15 it stays 15.
- Both bullets inside the opposing hit boxes in the same frame -> Hit0 = Hit1 = 1, RoundReset = 1, scores unchanged. A 8'h33 with Tank1Moving = 0 -> no Fire1 and no cooldown.
